// File: rtl/seg_pattern_decoder.sv
// Seven-segment receive decoder: synchronizes and debounces the segment bus, decodes settled
// patterns to character codes and tracks them against the 14-step name sequence.
module seg_pattern_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seg_in,
   output logic [3:0] char_code,
   output logic       char_valid,
   output logic       char_unknown,
   output logic [3:0] seq_pos,
   output logic       seq_done,
   output logic       seq_err,
   output logic [7:0] seq_count
);

   localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);
   localparam logic [3:0] LastStep  = 4'd13;

   typedef enum logic {StHunt, StTrack} state_e;

   function automatic logic [3:0] step_code(input logic [3:0] pos);
      case (pos)
         4'd0:    step_code = 4'd0;
         4'd1:    step_code = 4'd1;
         4'd2:    step_code = 4'd2;
         4'd3:    step_code = 4'd3;
         4'd4:    step_code = 4'd4;
         4'd5:    step_code = 4'd5;
         4'd6:    step_code = 4'd6;
         4'd7:    step_code = 4'd7;
         4'd8:    step_code = 4'd5;
         4'd9:    step_code = 4'd6;
         4'd10:   step_code = 4'd4;
         4'd11:   step_code = 4'd3;
         4'd12:   step_code = 4'd7;
         4'd13:   step_code = 4'd5;
         default: step_code = 4'd15;
      endcase
   endfunction

   logic [7:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [7:0] cand_q, cand_d, last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   state_e     state_q, state_d;
   logic [3:0] pos_q, pos_d, code_q, code_d;
   logic       unk_q, unk_d, valid_q, valid_d, done_q, done_d, err_q, err_d;
   logic [7:0] count_q, count_d;
   logic       accept;
   logic [3:0] dec_code;
   logic       dec_known;

   always_comb begin
      sync1_d = seg_in;
      sync2_d = sync1_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = 8'd1;
      end else begin
         cand_d = cand_q;
         cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end
      // Fires on the edge the counter reaches the threshold, so a held pattern is accepted once.
      accept = (cnt_d == StableCnt) && (cand_d != last_q);
   end

   always_comb begin
      dec_known = 1'b1;
      case (cand_d)
         8'h80:   dec_code = 4'd0;
         8'h5B:   dec_code = 4'd1;
         8'h4F:   dec_code = 4'd2;
         8'h15:   dec_code = 4'd3;
         8'h7E:   dec_code = 4'd4;
         8'h0E:   dec_code = 4'd5;
         8'h5F:   dec_code = 4'd6;
         8'h3E:   dec_code = 4'd7;
         default: begin
            dec_code  = 4'd15;
            dec_known = 1'b0;
         end
      endcase
   end

   always_comb begin
      last_d  = last_q;
      code_d  = code_q;
      unk_d   = unk_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      state_d = state_q;
      pos_d   = pos_q;
      count_d = count_q;
      if (accept) begin
         last_d = cand_d;
         if (cand_d != 8'h00) begin
            valid_d = 1'b1;
            code_d  = dec_code;
            unk_d   = ~dec_known;
            case (state_q)
               StHunt: begin
                  if (dec_code == 4'd0) begin
                     state_d = StTrack;
                     pos_d   = 4'd1;
                  end
               end
               default: begin
                  if (dec_code == step_code(pos_q)) begin
                     if (pos_q == LastStep) begin
                        done_d  = 1'b1;
                        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                        state_d = StHunt;
                        pos_d   = 4'd0;
                     end else begin
                        pos_d = pos_q + 4'd1;
                     end
                  end else begin
                     err_d = 1'b1;
                     // A stray dp is taken as the start of a fresh pass.
                     if (dec_code == 4'd0) begin
                        pos_d = 4'd1;
                     end else begin
                        state_d = StHunt;
                        pos_d   = 4'd0;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
         cand_q  <= 8'h00;
         last_q  <= 8'h00;
         cnt_q   <= 8'h00;
         state_q <= StHunt;
         pos_q   <= 4'd0;
         code_q  <= 4'd0;
         unk_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= 8'h00;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cand_q  <= cand_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         pos_q   <= pos_d;
         code_q  <= code_d;
         unk_q   <= unk_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   assign char_code    = code_q;
   assign char_valid   = valid_q;
   assign char_unknown = unk_q;
   assign seq_pos      = pos_q;
   assign seq_done     = done_q;
   assign seq_err      = err_q;
   assign seq_count    = count_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Bench for seg_pattern_decoder: directed table and corner sequences, then randomized segment
// streams checked against an event-level reference model.
module tb_seg_pattern_decoder;

   localparam int unsigned STABLE = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] seg_in;
   logic [3:0] char_code;
   logic       char_valid;
   logic       char_unknown;
   logic [3:0] seq_pos;
   logic       seq_done;
   logic       seq_err;
   logic [7:0] seq_count;

   seg_pattern_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk          (clk),
      .rst          (rst),
      .seg_in       (seg_in),
      .char_code    (char_code),
      .char_valid   (char_valid),
      .char_unknown (char_unknown),
      .seq_pos      (seq_pos),
      .seq_done     (seq_done),
      .seq_err      (seq_err),
      .seq_count    (seq_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] code;
      logic       unk;
      logic       err;
      logic       done;
      logic [3:0] pos;
      logic [7:0] count;
   } ev_t;

   typedef struct {
      logic [7:0] pat;
      int         code;
      int         pos;
      bit         done;
      int         cnt;
   } vec_t;

   int  total = 0;
   int  bad = 0;
   int  stray = 0;
   ev_t obs_q[$];
   ev_t exp_q[$];

   int         seq_codes[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 5, 6, 4, 3, 7, 5};
   logic [7:0] pat_of[8] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E};

   // Reference model state: pos 0 means hunting for dp.
   logic [7:0] m_last;
   int         m_pos;
   int         m_cnt;

   always @(posedge clk) begin
      #1;
      if (char_valid === 1'b1)
         obs_q.push_back({char_code, char_unknown, seq_err, seq_done, seq_pos, seq_count});
      else if (seq_err === 1'b1 || seq_done === 1'b1)
         stray++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic ev_t mk_ev(int code, bit unk, bit err, bit done, int pos, int cnt);
      ev_t e;
      e.code  = 4'(code);
      e.unk   = unk;
      e.err   = err;
      e.done  = done;
      e.pos   = 4'(pos);
      e.count = 8'(cnt);
      return e;
   endfunction

   function automatic int code_of(logic [7:0] pat);
      for (int i = 0; i < 8; i++) if (pat_of[i] == pat) return i;
      return 15;
   endfunction

   task automatic drive(input logic [7:0] pat, input int hold);
      seg_in = pat;
      repeat (hold) @(negedge clk);
   endtask

   task automatic model_seg(input logic [7:0] pat, input int hold);
      int  code;
      bit  err;
      bit  done;
      if (hold >= int'(STABLE) && pat != m_last) begin
         m_last = pat;
         if (pat != 8'h00) begin
            code = code_of(pat);
            err  = 0;
            done = 0;
            if (m_pos == 0) begin
               if (code == 0) m_pos = 1;
            end else if (code == seq_codes[m_pos]) begin
               if (m_pos == 13) begin
                  done  = 1;
                  m_pos = 0;
                  if (m_cnt < 255) m_cnt++;
               end else begin
                  m_pos++;
               end
            end else begin
               err   = 1;
               m_pos = (code == 0) ? 1 : 0;
            end
            exp_q.push_back(mk_ev(code, code == 15, err, done, m_pos, m_cnt));
         end
      end
   endtask

   function automatic logic [19:0] outs();
      return {char_code, char_unknown, char_valid, seq_pos, seq_done, seq_err, seq_count};
   endfunction

   vec_t       vecs[14];
   logic [7:0] pat;
   logic [7:0] prev;
   int         hold;
   int         r;
   int         first;
   int         width;
   int         dones;

   initial begin
      for (int i = 0; i < 14; i++) begin
         vecs[i].pat  = pat_of[seq_codes[i]];
         vecs[i].code = seq_codes[i];
         vecs[i].pos  = (i == 13) ? 0 : i + 1;
         vecs[i].done = (i == 13);
         vecs[i].cnt  = (i == 13) ? 1 : 0;
      end

      // Reset with S present; outputs stay clear, then S is accepted but ignored by the tracker.
      rst    = 1'b1;
      seg_in = 8'h5B;
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", 32'(outs()), 32'h0);
      end
      rst = 1'b0;
      obs_q.delete();
      repeat (10) @(negedge clk);
      chk("reset_release_pulses", obs_q.size(), 1);
      if (obs_q.size() > 0) chk("reset_release_event", obs_q[0], mk_ev(1, 0, 0, 0, 0, 0));

      // Full sequence from the vector table.
      for (int i = 0; i < 14; i++) begin
         obs_q.delete();
         drive(vecs[i].pat, 6);
         chk("seq_step_pulses", obs_q.size(), 1);
         if (obs_q.size() > 0)
            chk("seq_step_event", obs_q[0],
                mk_ev(vecs[i].code, 0, 0, vecs[i].done, vecs[i].pos, vecs[i].cnt));
      end
      chk("seq_count_after_pass", seq_count, 1);

      // Short S glitch rejected, E accepted once even when held long.
      obs_q.delete();
      drive(8'h5B, 3);
      drive(8'h4F, 10);
      chk("glitch_pulses", obs_q.size(), 1);
      if (obs_q.size() > 0) chk("glitch_event", obs_q[0], mk_ev(2, 0, 0, 0, 0, 1));
      obs_q.delete();
      drive(8'h4F, 50);
      chk("held_no_repulse", obs_q.size(), 0);

      // Out-of-order G, then dp restart and dp resync.
      obs_q.delete();
      drive(8'h80, 6);
      drive(8'h5B, 6);
      drive(8'h5F, 6);
      chk("ooo_pulses", obs_q.size(), 3);
      if (obs_q.size() == 3) chk("ooo_err_event", obs_q[2], mk_ev(6, 0, 1, 0, 0, 1));
      obs_q.delete();
      drive(8'h80, 6);
      if (obs_q.size() > 0) chk("dp_after_err", obs_q[0], mk_ev(0, 0, 0, 0, 1, 1));
      drive(8'h00, 6);
      obs_q.delete();
      drive(8'h80, 6);
      chk("dp_resync_pulses", obs_q.size(), 1);
      if (obs_q.size() > 0) chk("dp_resync_event", obs_q[0], mk_ev(0, 0, 1, 0, 1, 1));

      // Back to hunt, then unknown pattern in track and in hunt.
      obs_q.delete();
      drive(8'h3E, 6);
      drive(8'h80, 6);
      drive(8'h01, 6);
      drive(8'h00, 6);
      drive(8'h01, 6);
      chk("unknown_pulses", obs_q.size(), 4);
      if (obs_q.size() == 4) begin
         chk("u_to_hunt", obs_q[0], mk_ev(7, 0, 1, 0, 0, 1));
         chk("unknown_in_track", obs_q[2], mk_ev(15, 1, 1, 0, 0, 1));
         chk("unknown_in_hunt", obs_q[3], mk_ev(15, 1, 0, 0, 0, 1));
      end

      // Reset part-way through a pass.
      drive(8'h80, 6);
      drive(8'h5B, 6);
      drive(8'h4F, 6);
      drive(8'h15, 6);
      drive(8'h7E, 6);
      chk("pos_before_reset", seq_pos, 5);
      obs_q.delete();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset_outputs", 32'(outs()), 32'h0);
      rst = 1'b0;
      drive(8'h0E, 8);
      chk("post_reset_pulses", obs_q.size(), 1);
      if (obs_q.size() > 0) chk("post_reset_event", obs_q[0], mk_ev(5, 0, 0, 0, 0, 0));

      // Exact accept latency and pulse width.
      first = 0;
      width = 0;
      seg_in = 8'h3E;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk);
         #1;
         if (char_valid === 1'b1) begin
            width++;
            if (first == 0) first = i;
         end
      end
      @(negedge clk);
      chk("accept_latency", first, STABLE + 2);
      chk("pulse_width", width, 1);

      // Pass counter saturation.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      for (int p = 0; p < 256; p++)
         for (int i = 0; i < 14; i++) drive(pat_of[seq_codes[i]], STABLE);
      drive(8'h00, 10);
      dones = 0;
      foreach (obs_q[i]) if (obs_q[i].done) dones++;
      chk("sat_done_pulses", dones, 256);
      chk("sat_count", seq_count, 255);
      chk("sat_last_event", obs_q[obs_q.size() - 1], mk_ev(5, 0, 0, 1, 0, 255));

      // Randomized segment stream against the reference model.
      rst = 1'b1;
      seg_in = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      m_last = 8'h00;
      m_pos  = 0;
      m_cnt  = 0;
      prev   = 8'h00;
      obs_q.delete();
      exp_q.delete();
      for (int n = 0; n < 800; n++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 5) pat = pat_of[seq_codes[m_pos]];
         else if (r == 6) pat = 8'h00;
         else if (r == 7) pat = pat_of[$urandom_range(0, 7)];
         else if (r == 8) begin
            pat = 8'($urandom_range(1, 255));
            while (code_of(pat) != 15) pat = 8'($urandom_range(1, 255));
         end else pat = 8'h80;
         if (pat == prev) pat = (prev == 8'h00) ? 8'h80 : 8'h00;
         hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3))
                                            : int'($urandom_range(4, 9));
         model_seg(pat, hold);
         drive(pat, hold);
         prev = pat;
      end
      drive((prev == 8'h00) ? 8'h80 : 8'h00, 1);
      drive(prev, 12);
      chk("rand_event_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk("rand_event", obs_q[i], exp_q[i]);
      chk("stray_flags", stray, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_pattern_decoder.md
# seg_pattern_decoder

Receive-side counterpart of the seven-segment character stepper: samples an 8-bit segment bus (dp + a..g), filters out unsettled patterns, and decodes each newly settled pattern back to a 4-bit character code. A sequence tracker checks the decoded stream against the 14-step name sequence (dp, S, E, n, O, L, G, U, L, G, O, n, U, L). It reports completed passes and out-of-order characters. It sits in loopback/self-test logic, or on a board that snoops another tile's display pins.

## Interface
- STABLE_CYCLES, 4, consecutive synchronized samples a pattern must hold before acceptance; legal range 1..255
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- seg_in  in  8  segment bus; bit7 = dp, bits6..0 = a..g; asynchronous to clk
- char_code  out  4  code of last accepted character
- char_valid  out  1  one-cycle pulse per accepted non-blank pattern
- char_unknown  out  1  qualifies char_code; high when the accepted pattern is not in the table
- seq_pos  out  4  index of next expected sequence step, 0..13
- seq_done  out  1  one-cycle pulse when step 13 is matched
- seq_err  out  1  one-cycle pulse on an out-of-order character while tracking
- seq_count  out  8  completed passes, saturates at 255

## Operation
- Decode table (pattern -> code):
  - 0x80 dp -> 0
  - 0x5B S -> 1
  - 0x4F E -> 2
  - 0x15 n -> 3
  - 0x7E O -> 4
  - 0x0E L -> 5
  - 0x5F G -> 6
  - 0x3E U -> 7
  - 0x00 blank: no code, no pulse
  - any other pattern -> code 15, char_unknown=1
- Expected code per step 0..13: 0,1,2,3,4,5,6,7,5,6,4,3,7,5.
- Input path: two-flop synchronizer, then candidate register plus 8-bit stability counter.
  - Synchronized sample differs from candidate: load candidate, counter=1.
  - Otherwise: counter increments, saturating.
- Acceptance: counter reaches STABLE_CYCLES and candidate != last_accepted.
  - last_accepted <= candidate.
  - If non-blank: char_valid pulse with char_code/char_unknown.
  - A held pattern is accepted once only. A blank re-arms the same pattern.
- Tracker FSM, evaluated only on accepted non-blank characters:
  - HUNT (seq_pos=0): code 0 -> TRACK, seq_pos=1. Anything else is ignored, no error.
  - TRACK: code == expected[seq_pos] -> seq_pos+1.
    - At seq_pos 13: seq_done pulse, seq_count+1 (saturating), go to HUNT with seq_pos=0.
  - TRACK mismatch (including unknown): seq_err pulse.
    - Mismatching char is dp: resync, stay TRACK, seq_pos=1.
    - Otherwise: go to HUNT, seq_pos=0.
- Reset clears synchronizer, candidate, last_accepted (0x00), counter, FSM (HUNT), seq_pos, seq_count and every output to 0.

## Timing
- All outputs are registered.
- char_valid, seq_done and seq_err are coincident single-cycle pulses, updated on the same edge as the accept.
- Latency: pattern first captured by synchronizer stage 1 at edge E0 -> char_valid high in the cycle after edge E0+1+STABLE_CYCLES (default: edge E0+5).
- Glitches shorter than STABLE_CYCLES synchronized samples produce no pulse.
- char_code/char_unknown hold their value between pulses.
- seq_pos/seq_count change on the pulse edge.
- rst asserted mid-pattern: state cleared that cycle. After release, a still-present pattern needs the full synchronizer plus STABLE_CYCLES latency again.
- seq_count at 255 stays 255; seq_done still pulses.

## Test plan
- Reset with seg_in=0x5B, rst high 3 cycles -> all outputs 0 during reset. After release: one char_valid, code 1, no seq_err (HUNT ignores it), seq_pos 0.
- Full sequence, each pattern held 6 cycles -> 14 char_valid pulses with codes 0,1,2,3,4,5,6,7,5,6,4,3,7,5. Single seq_done coincident with the final L; seq_count=1; seq_pos back to 0; seq_err never high.
- 0x5B held 3 cycles, then 0x4F held 10 cycles (STABLE_CYCLES=4) -> exactly one char_valid, code 2. 0x4F held a further 50 cycles -> no additional pulse.
- dp, S, then 0x5F -> seq_err with G's char_valid, seq_pos 0. Then dp -> seq_pos 1, no seq_err. Then dp again -> seq_err, seq_pos 1 (resync).
- dp then 0x01 -> char_valid with code 15, char_unknown=1, seq_err, seq_pos 0. Then 0x00 then 0x01 -> second unknown pulse, no seq_err (HUNT).
- Run to after O (seq_pos 5), assert rst 1 cycle, then present L -> char_valid code 5, seq_pos 0, no seq_err, seq_count 0.
